// File: rtl/spike_time_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spike_time_encoder: multi-channel time-to-first-spike transmitter           |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module spike_time_encoder #(
  parameter int N_CHANNELS  = 4,
  parameter int DTT_WIDTH   = 5,
  parameter bit INVERT      = 1'b0,
  parameter bit ZERO_SILENT = 1'b0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_CHANNELS*DTT_WIDTH-1:0]  in_vector,
  output logic [N_CHANNELS-1:0]            spikes,
  output logic                             window_start,
  output logic                             done,
  output logic                             busy
);

  localparam int                 WIN    = 1 << DTT_WIDTH;
  localparam logic [DTT_WIDTH:0] T_LAST = (DTT_WIDTH+1)'(WIN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [DTT_WIDTH:0]              t_q, t_d;
  logic [N_CHANNELS*DTT_WIDTH-1:0] vals_q, vals_d;
  logic [N_CHANNELS-1:0]           spikes_q, spikes_d;
  logic                            ws_q, ws_d;
  logic                            done_q, done_d;
  logic                            w_ready;
  logic                            w_accept;

  assign w_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign w_accept = in_valid && w_ready;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    vals_d  = vals_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          state_d = S_RUN;
          t_d     = '0;
          vals_d  = in_vector;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (t_q == T_LAST) begin
          state_d = S_DONE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ws_d   = w_accept;
    done_d = (state_d == S_DONE);
  end

  // Spikes are decided from next-state values so the registered pulse lands in cycle k+1+off.
  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
    logic [DTT_WIDTH-1:0] w_val;
    logic [DTT_WIDTH-1:0] w_off;
    logic                 w_en;
    assign w_val       = vals_d[i*DTT_WIDTH +: DTT_WIDTH];
    assign w_off       = INVERT ? ~w_val : w_val;
    assign w_en        = !(ZERO_SILENT && (w_val == '0));
    assign spikes_d[i] = (state_d == S_RUN) && w_en && (w_off == t_d[DTT_WIDTH-1:0]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      vals_q   <= '0;
      spikes_q <= '0;
      ws_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      vals_q   <= vals_d;
      spikes_q <= spikes_d;
      ws_q     <= ws_d;
      done_q   <= done_d;
    end
  end

  assign in_ready     = !RST && w_ready;
  assign spikes       = RST ? '0 : spikes_q;
  assign window_start = !RST && ws_q;
  assign done         = !RST && done_q;
  assign busy         = !RST && (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_spike_time_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spike_time_encoder: directed bench for default, INVERT and ZERO_SILENT   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_spike_time_encoder;

  localparam int N = 4;
  localparam int W = 5;

  logic                 clk = 1'b0;
  logic                 RST;
  logic                 in_valid;
  logic [N*W-1:0]       in_vector;
  logic [2:0]           rdy, ws, dn, bz;
  logic [2:0][N-1:0]    spk;

  logic [2:0][N-1:0]    h_spk [0:127];
  logic [2:0]           h_ws  [0:127];
  logic [2:0]           h_dn  [0:127];
  logic [2:0]           h_rdy [0:127];
  logic [2:0]           h_bz  [0:127];

  int checks = 0;
  int errors = 0;

  localparam logic [N*W-1:0] VEC_A = {5'd31, 5'd0, 5'd7, 5'd15};
  localparam logic [N*W-1:0] VEC_B = {5'd1, 5'd2, 5'd3, 5'd4};
  localparam logic [N*W-1:0] VEC_Z = {5'd0, 5'd5, 5'd5, 5'd0};
  localparam logic [N*W-1:0] VEC_R = {5'd3, 5'd20, 5'd20, 5'd31};

  always #5 clk = ~clk;

  spike_time_encoder #(.N_CHANNELS(N), .DTT_WIDTH(W), .INVERT(1'b0), .ZERO_SILENT(1'b0)) u_def (
    .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(rdy[0]), .in_vector(in_vector),
    .spikes(spk[0]), .window_start(ws[0]), .done(dn[0]), .busy(bz[0]));

  spike_time_encoder #(.N_CHANNELS(N), .DTT_WIDTH(W), .INVERT(1'b1), .ZERO_SILENT(1'b0)) u_inv (
    .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(rdy[1]), .in_vector(in_vector),
    .spikes(spk[1]), .window_start(ws[1]), .done(dn[1]), .busy(bz[1]));

  spike_time_encoder #(.N_CHANNELS(N), .DTT_WIDTH(W), .INVERT(1'b0), .ZERO_SILENT(1'b1)) u_zs (
    .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(rdy[2]), .in_vector(in_vector),
    .spikes(spk[2]), .window_start(ws[2]), .done(dn[2]), .busy(bz[2]));

  task automatic chk_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic get_bit(input int kind, input int d, input int ch, input int j);
    case (kind)
      0:       return h_spk[j][d][ch];
      1:       return h_ws[j][d];
      2:       return h_dn[j][d];
      3:       return h_rdy[j][d];
      default: return h_bz[j][d];
    endcase
  endfunction

  function automatic int cnt(input int kind, input int d, input int ch, input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (get_bit(kind, d, ch, j)) n++;
    return n;
  endfunction

  function automatic int first(input int kind, input int d, input int ch);
    for (int j = 1; j < 128; j++) if (get_bit(kind, d, ch, j)) return j;
    return -1;
  endfunction

  function automatic int last(input int kind, input int d, input int ch);
    for (int j = 127; j >= 1; j--) if (get_bit(kind, d, ch, j)) return j;
    return -1;
  endfunction

  // Present a vector before edge k; the following observe() starts at cycle k+1.
  task automatic accept(input logic [N*W-1:0] vec);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_vector = vec;
    #2;
    chk_eq("rdy_before_accept", int'(rdy[0]), 1);
  endtask

  task automatic observe(input int ncyc, input int on_at, input logic [N*W-1:0] pv,
                         input int off_at, input int rst_at);
    for (int j = 0; j < 128; j++) begin
      h_spk[j] = '0; h_ws[j] = '0; h_dn[j] = '0; h_rdy[j] = '0; h_bz[j] = '0;
    end
    for (int j = 1; j <= ncyc; j++) begin
      @(posedge clk); #1;
      if (j == on_at) begin
        in_valid  = 1'b1;
        in_vector = pv;
      end
      if (j == off_at) in_valid = 1'b0;
      if (j == rst_at) RST = 1'b1;
      if (j == rst_at + 1) RST = 1'b0;
      #2;
      h_spk[j] = spk; h_ws[j] = ws; h_dn[j] = dn; h_rdy[j] = rdy; h_bz[j] = bz;
    end
  endtask

  task automatic check_plain(input string tag);
    chk_eq({tag, "_sp0"}, first(0, 0, 0), 16);
    chk_eq({tag, "_sp1"}, first(0, 0, 1), 8);
    chk_eq({tag, "_sp2"}, first(0, 0, 2), 1);
    chk_eq({tag, "_sp3"}, first(0, 0, 3), 32);
    for (int c = 0; c < N; c++) chk_eq($sformatf("%s_cnt%0d", tag, c), cnt(0, 0, c, 1, 40), 1);
    chk_eq({tag, "_ws_first"}, first(1, 0, 0), 1);
    chk_eq({tag, "_ws_cnt"}, cnt(1, 0, 0, 1, 40), 1);
    chk_eq({tag, "_done_first"}, first(2, 0, 0), 33);
    chk_eq({tag, "_done_cnt"}, cnt(2, 0, 0, 1, 40), 1);
  endtask

  initial begin
    RST       = 1'b1;
    in_valid  = 1'b1;
    in_vector = VEC_B;
    repeat (3) @(posedge clk);
    #3;
    chk_eq("rst_ready", int'(rdy[0]), 0);
    chk_eq("rst_spikes", int'(spk[0]), 0);
    chk_eq("rst_busy", int'(bz[0]), 0);
    chk_eq("rst_done", int'(dn[0]), 0);
    chk_eq("rst_ws", int'(ws[0]), 0);
    RST      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #3;
    chk_eq("post_rst_ready", int'(rdy[0]), 1);
    chk_eq("post_rst_busy", int'(bz[0]), 0);

    // Plain window on all three variants
    accept(VEC_A);
    observe(40, -1, '0, 1, -1);
    check_plain("t1");
    chk_eq("t1_rdy_run", cnt(3, 0, 0, 1, 32), 0);
    chk_eq("t1_busy_run", cnt(4, 0, 0, 1, 32), 32);
    chk_eq("t1_busy_done", cnt(4, 0, 0, 33, 33), 0);
    chk_eq("t1_spk_done", cnt(0, 0, 0, 33, 33) + cnt(0, 0, 3, 33, 33), 0);
    chk_eq("t2_sp0", first(0, 1, 0), 17);
    chk_eq("t2_sp1", first(0, 1, 1), 25);
    chk_eq("t2_sp2", first(0, 1, 2), 32);
    chk_eq("t2_sp3", first(0, 1, 3), 1);
    chk_eq("t2_done", first(2, 1, 0), 33);
    chk_eq("zs_a_sp2_cnt", cnt(0, 2, 2, 1, 40), 0);
    chk_eq("zs_a_sp0", first(0, 2, 0), 16);

    // Zero-silent channels
    accept(VEC_Z);
    observe(40, -1, '0, 1, -1);
    chk_eq("t3_sp0_cnt", cnt(0, 2, 0, 1, 40), 0);
    chk_eq("t3_sp3_cnt", cnt(0, 2, 3, 1, 40), 0);
    chk_eq("t3_sp1", first(0, 2, 1), 6);
    chk_eq("t3_sp2", first(0, 2, 2), 6);
    chk_eq("t3_done", first(2, 2, 0), 33);
    chk_eq("t3_def_sp0", first(0, 0, 0), 1);

    // Back-to-back with in_valid held high
    accept(VEC_A);
    observe(72, 1, VEC_B, 34, -1);
    chk_eq("t4_rdy_run", cnt(3, 0, 0, 1, 32), 0);
    chk_eq("t4_rdy_done", cnt(3, 0, 0, 33, 33), 1);
    chk_eq("t4_ws_cnt", cnt(1, 0, 0, 1, 72), 2);
    chk_eq("t4_ws_last", last(1, 0, 0), 34);
    chk_eq("t4_done_first", first(2, 0, 0), 33);
    chk_eq("t4_done_last", last(2, 0, 0), 66);
    chk_eq("t4_done_cnt", cnt(2, 0, 0, 1, 72), 2);
    chk_eq("t4_sp0_last", last(0, 0, 0), 38);
    chk_eq("t4_sp3_last", last(0, 0, 3), 35);
    chk_eq("t4_sp0_cnt", cnt(0, 0, 0, 1, 72), 2);

    // in_valid pulse during RUN is ignored
    accept(VEC_A);
    observe(40, 5, VEC_B, 6, -1);
    check_plain("t5");

    // Reset mid-window
    accept(VEC_R);
    observe(40, -1, '0, 1, 10);
    chk_eq("t6_sp3", first(0, 0, 3), 4);
    chk_eq("t6_sp3_cnt", cnt(0, 0, 3, 1, 40), 1);
    chk_eq("t6_sp0_cnt", cnt(0, 0, 0, 1, 40), 0);
    chk_eq("t6_sp1_cnt", cnt(0, 0, 1, 1, 40), 0);
    chk_eq("t6_sp2_cnt", cnt(0, 0, 2, 1, 40), 0);
    chk_eq("t6_done_cnt", cnt(2, 0, 0, 1, 40), 0);
    chk_eq("t6_rdy_in_rst", cnt(3, 0, 0, 10, 10), 0);
    chk_eq("t6_busy_in_rst", cnt(4, 0, 0, 10, 10), 0);
    chk_eq("t6_rdy_after", cnt(3, 0, 0, 11, 11), 1);
    chk_eq("t6_busy_after", cnt(4, 0, 0, 11, 11), 0);
    accept(VEC_A);
    observe(40, -1, '0, 1, -1);
    check_plain("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
